// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundle of the fetch request port, the data-memory request
//                port and the single-port memory macro port that meet at
//                mem_port_arbiter.
//                slave  : the arbiter's view (takes requests, drives memory).
//                master : the requesters' and memory's view.
//  Signals     : if_req/if_addr/if_gnt/if_rvalid/if_stall   fetch side
//                dm_req/dm_we/dm_addr/dm_wdata/dm_gnt/dm_rvalid  data side
//                rdata                                         shared read data
//                mem_en/mem_we/mem_addr/mem_wdata/mem_rdata    memory macro
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int XLEN = 64
);
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic            if_stall;

  logic            dm_req;
  logic            dm_we;
  logic [XLEN-1:0] dm_addr;
  logic [XLEN-1:0] dm_wdata;
  logic            dm_gnt;
  logic            dm_rvalid;

  logic [XLEN-1:0] rdata;

  logic            mem_en;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_stall, dm_gnt, dm_rvalid, rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_stall, dm_gnt, dm_rvalid, rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port memory between instruction fetch (IF)
//                and the load/store path (DM). At most one access is issued
//                per cycle; every read in flight carries an owner tag so the
//                returned data is steered to the right requester
//                MEM_LATENCY+1 cycles after its grant.
//  Parameters  : XLEN         data/address width
//                MEM_LATENCY  cycles from mem_en to mem_rdata valid (1..4)
//                STARVE_LIMIT consecutive IF losses before IF is forced to win
//  Ports       : clk  rising-edge clock
//                rst  synchronous active-high reset
//                bus  mem_port_arbiter_if.slave (requests, grants, read
//                     return, fetch stall, memory macro signals)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int XLEN         = 64,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input wire                clk,
  input wire                rst,
  mem_port_arbiter_if.slave bus
);

  localparam int                 c_CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STARVE_LIMIT);

  localparam logic [0:0] c_ST_NORMAL     = 1'b0;
  localparam logic [0:0] c_ST_FETCH_PRIO = 1'b1;

  logic [0:0]             r_state;
  logic [0:0]             w_state_nxt;
  logic [c_CNT_W-1:0]     r_starve_cnt;
  logic [c_CNT_W-1:0]     w_starve_cnt_nxt;
  logic                   w_if_gnt;
  logic                   w_dm_gnt;

  logic [MEM_LATENCY-1:0] r_tag_vld;
  logic [MEM_LATENCY-1:0] r_tag_own;   // 1 = IF owns the read, 0 = DM
  logic                   r_if_rvalid;
  logic                   r_dm_rvalid;
  logic [XLEN-1:0]        r_rdata;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_NORMAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. Fetch takes priority once it has lost STARVE_LIMIT
  // arbitrations in a row, and gives it back right after its first win.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_NORMAL: begin
        if (w_starve_cnt_nxt == c_CNT_MAX) begin
          w_state_nxt = c_ST_FETCH_PRIO;
        end
      end
      c_ST_FETCH_PRIO: begin
        if (w_if_gnt) begin
          w_state_nxt = c_ST_NORMAL;
        end
      end
      default: w_state_nxt = c_ST_NORMAL;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (grants). Grants are held low during reset so nothing
  // reaches the memory while the pipeline is being cleared.
  // --------------------------------------------------------------------------
  always_comb begin
    w_if_gnt = 1'b0;
    w_dm_gnt = 1'b0;
    if (!rst) begin
      if (r_state == c_ST_FETCH_PRIO) begin
        if (bus.if_req) begin
          w_if_gnt = 1'b1;
        end else if (bus.dm_req) begin
          w_dm_gnt = 1'b1;
        end
      end else begin
        if (bus.dm_req) begin
          w_dm_gnt = 1'b1;
        end else if (bus.if_req) begin
          w_if_gnt = 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Starvation counter: counts consecutive cycles where fetch waits behind a
  // data access; saturates at STARVE_LIMIT.
  // --------------------------------------------------------------------------
  always_comb begin
    w_starve_cnt_nxt = r_starve_cnt;
    if (!bus.if_req || w_if_gnt) begin
      w_starve_cnt_nxt = '0;
    end else if (w_dm_gnt && (r_starve_cnt != c_CNT_MAX)) begin
      w_starve_cnt_nxt = r_starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else begin
      r_starve_cnt <= w_starve_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Owner tag pipeline, one stage per cycle of memory latency. Stores enter
  // invalid so they never produce a read response.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld <= '0;
      r_tag_own <= '0;
    end else begin
      r_tag_vld[0] <= w_if_gnt | (w_dm_gnt & ~bus.dm_we);
      r_tag_own[0] <= w_if_gnt;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_own[i] <= r_tag_own[i-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read return: capture memory data when the oldest tag is valid; rdata
  // keeps its last value otherwise.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_if_rvalid <= r_tag_vld[MEM_LATENCY-1] &  r_tag_own[MEM_LATENCY-1];
      r_dm_rvalid <= r_tag_vld[MEM_LATENCY-1] & ~r_tag_own[MEM_LATENCY-1];
      if (r_tag_vld[MEM_LATENCY-1]) begin
        r_rdata <= bus.mem_rdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign bus.if_gnt    = w_if_gnt;
  assign bus.dm_gnt    = w_dm_gnt;
  assign bus.if_stall  = ~rst & bus.if_req & ~w_if_gnt;
  assign bus.mem_en    = w_if_gnt | w_dm_gnt;
  assign bus.mem_we    = w_dm_gnt & bus.dm_we;
  assign bus.mem_addr  = w_if_gnt ? bus.if_addr :
                         (w_dm_gnt ? bus.dm_addr : '0);
  assign bus.mem_wdata = w_dm_gnt ? bus.dm_wdata : '0;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.dm_rvalid = r_dm_rvalid;
  assign bus.rdata     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. Two instances
//                (MEM_LATENCY 1 and 2, STARVE_LIMIT 4) see identical
//                directed stimulus; each has its own memory model. A
//                reference model predicts every output on every cycle, and
//                directed steps carry hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        mem_first = 1'b1;
  logic        drv_if_req = 1'b0;
  logic        drv_dm_req = 1'b0;
  logic        drv_dm_we = 1'b0;
  logic [63:0] drv_if_addr = '0;
  logic [63:0] drv_dm_addr = '0;
  logic [63:0] drv_dm_wdata = '0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  mem_port_arbiter_if #(.XLEN(64)) bus1 ();
  mem_port_arbiter_if #(.XLEN(64)) bus2 ();

  assign bus1.if_req   = drv_if_req;
  assign bus1.if_addr  = drv_if_addr;
  assign bus1.dm_req   = drv_dm_req;
  assign bus1.dm_we    = drv_dm_we;
  assign bus1.dm_addr  = drv_dm_addr;
  assign bus1.dm_wdata = drv_dm_wdata;
  assign bus2.if_req   = drv_if_req;
  assign bus2.if_addr  = drv_if_addr;
  assign bus2.dm_req   = drv_dm_req;
  assign bus2.dm_we    = drv_dm_we;
  assign bus2.dm_addr  = drv_dm_addr;
  assign bus2.dm_wdata = drv_dm_wdata;

  mem_port_arbiter #(.XLEN(64), .MEM_LATENCY(1), .STARVE_LIMIT(LIMIT)) u_dut_l1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  mem_port_arbiter #(.XLEN(64), .MEM_LATENCY(2), .STARVE_LIMIT(LIMIT)) u_dut_l2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Memory content before any store: recognisable per-address pattern.
  function automatic logic [63:0] init_word(input logic [7:0] idx);
    return {32'hA5A5_5A5A, 22'd0, idx, 2'b00};
  endfunction

  // --------------------------------------------------------------------------
  // Memory macros (one per instance), indexed by byte address bits [9:2]
  // --------------------------------------------------------------------------
  logic [63:0] mem1 [256];
  logic [63:0] mem2 [256];
  logic [63:0] p1 = '1;
  logic [63:0] p2a = '1;
  logic [63:0] p2b = '1;

  always @(posedge clk) begin
    if (mem_first) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= init_word(8'(i));
        mem2[i] <= init_word(8'(i));
      end
    end else begin
      if (bus1.mem_en && bus1.mem_we) mem1[bus1.mem_addr[9:2]] <= bus1.mem_wdata;
      if (bus2.mem_en && bus2.mem_we) mem2[bus2.mem_addr[9:2]] <= bus2.mem_wdata;
    end
    p1  <= (bus1.mem_en && !bus1.mem_we) ? mem1[bus1.mem_addr[9:2]] : '1;
    p2a <= (bus2.mem_en && !bus2.mem_we) ? mem2[bus2.mem_addr[9:2]] : '1;
    p2b <= p2a;
  end

  assign bus1.mem_rdata = p1;
  assign bus2.mem_rdata = p2b;

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, 64'(act), 64'(exp));
  endtask

  // --------------------------------------------------------------------------
  // Reference model: who wins this cycle, what the memory sees, and a queue
  // of expected read responses (due cycle, owner, data from a golden memory).
  // --------------------------------------------------------------------------
  typedef struct {
    int          due;
    logic        own;
    logic [63:0] data;
  } rsp_t;

  rsp_t        q1[$];
  rsp_t        q2[$];
  logic [63:0] gm [256];
  logic        m_prio = 1'b0;  // fetch currently has priority
  int          m_lost = 0;     // consecutive arbitrations fetch has lost

  logic        e_ig, e_dg, e_st, e_en, e_we;
  logic [63:0] e_ad, e_wd;
  logic [1:0]  e_iv, e_dv;
  logic [63:0] e_rd [2] = '{64'd0, 64'd0};

  task automatic chk_inst(input string tag, input int k,
                          input logic ig, input logic dg, input logic st,
                          input logic en, input logic we,
                          input logic [63:0] ad, input logic [63:0] wd,
                          input logic iv, input logic dv, input logic [63:0] rd);
    chk1({tag, ".if_gnt"},    ig, e_ig);
    chk1({tag, ".dm_gnt"},    dg, e_dg);
    chk1({tag, ".if_stall"},  st, e_st);
    chk1({tag, ".mem_en"},    en, e_en);
    chk1({tag, ".mem_we"},    we, e_we);
    chk ({tag, ".mem_addr"},  ad, e_ad);
    chk ({tag, ".mem_wdata"}, wd, e_wd);
    chk1({tag, ".if_rvalid"}, iv, e_iv[k]);
    chk1({tag, ".dm_rvalid"}, dv, e_dv[k]);
    chk ({tag, ".rdata"},     rd, e_rd[k]);
  endtask

  always @(negedge clk) begin
    rsp_t r;
    cyc++;
    if (cyc == 1) begin
      for (int i = 0; i < 256; i++) gm[i] = init_word(8'(i));
    end

    e_ig = 1'b0;
    e_dg = 1'b0;
    if (!rst) begin
      if (m_prio && drv_if_req)  e_ig = 1'b1;
      else if (drv_dm_req)       e_dg = 1'b1;
      else if (drv_if_req)       e_ig = 1'b1;
    end
    e_st = !rst && drv_if_req && !e_ig;
    e_en = e_ig || e_dg;
    e_we = e_dg && drv_dm_we;
    e_ad = e_ig ? drv_if_addr : (e_dg ? drv_dm_addr : 64'd0);
    e_wd = e_dg ? drv_dm_wdata : 64'd0;

    e_iv = 2'b00;
    e_dv = 2'b00;
    if (q1.size() > 0 && q1[0].due == cyc) begin
      r = q1.pop_front();
      if (r.own) e_iv[0] = 1'b1; else e_dv[0] = 1'b1;
      e_rd[0] = r.data;
    end
    if (q2.size() > 0 && q2[0].due == cyc) begin
      r = q2.pop_front();
      if (r.own) e_iv[1] = 1'b1; else e_dv[1] = 1'b1;
      e_rd[1] = r.data;
    end

    chk_inst("L1", 0, bus1.if_gnt, bus1.dm_gnt, bus1.if_stall, bus1.mem_en, bus1.mem_we,
             bus1.mem_addr, bus1.mem_wdata, bus1.if_rvalid, bus1.dm_rvalid, bus1.rdata);
    chk_inst("L2", 1, bus2.if_gnt, bus2.dm_gnt, bus2.if_stall, bus2.mem_en, bus2.mem_we,
             bus2.mem_addr, bus2.mem_wdata, bus2.if_rvalid, bus2.dm_rvalid, bus2.rdata);

    // advance the model across the coming clock edge
    if (rst) begin
      m_prio = 1'b0;
      m_lost = 0;
      q1.delete();
      q2.delete();
      e_rd[0] = 64'd0;
      e_rd[1] = 64'd0;
    end else begin
      if (e_ig || (e_dg && !drv_dm_we)) begin
        r.own  = e_ig;
        r.data = gm[e_ad[9:2]];
        r.due  = cyc + 2;
        q1.push_back(r);
        r.due  = cyc + 3;
        q2.push_back(r);
      end
      if (e_we) gm[e_ad[9:2]] = drv_dm_wdata;
      if (e_ig || !drv_if_req) m_lost = 0;
      else if (e_dg && m_lost < LIMIT) m_lost++;
      if (!m_prio && m_lost == LIMIT) m_prio = 1'b1;
      else if (m_prio && e_ig) m_prio = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic set_in(input logic r, input logic ir, input logic [63:0] ia,
                        input logic dr, input logic dwe, input logic [63:0] da,
                        input logic [63:0] dwd);
    rst          = r;
    drv_if_req   = ir;
    drv_if_addr  = ia;
    drv_dm_req   = dr;
    drv_dm_we    = dwe;
    drv_dm_addr  = da;
    drv_dm_wdata = dwd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
      step();
    end
  endtask

  initial begin
    // reset held 3 cycles with both requests high
    set_in(1'b1, 1'b1, 64'h10, 1'b1, 1'b0, 64'h20, 64'd0);
    #1;
    chk1("t1_rst_if_gnt", bus1.if_gnt, 1'b0);
    chk1("t1_rst_dm_gnt", bus1.dm_gnt, 1'b0);
    chk1("t1_rst_stall",  bus1.if_stall, 1'b0);
    chk1("t1_rst_mem_en", bus1.mem_en, 1'b0);
    step();
    mem_first = 1'b0;
    step();
    step();
    // first cycle out of reset: NORMAL, data side wins
    set_in(1'b0, 1'b1, 64'h10, 1'b1, 1'b0, 64'h20, 64'd0);
    #1;
    chk1("t1_post_dm_gnt", bus1.dm_gnt, 1'b1);
    chk1("t1_post_if_gnt", bus1.if_gnt, 1'b0);
    chk ("t1_post_rdata",  bus1.rdata, 64'd0);
    step();
    set_in(1'b0, 1'b1, 64'h10, 1'b0, 1'b0, 64'd0, 64'd0);
    #1;
    chk1("t1_post_if_gnt2", bus1.if_gnt, 1'b1);
    step();
    idle(4);

    // fetch-only burst 0x0, 0x4, 0x8
    set_in(1'b0, 1'b1, 64'h0, 1'b0, 1'b0, 64'd0, 64'd0);
    #1; chk1("t2_gnt0", bus1.if_gnt, 1'b1);
    step();
    set_in(1'b0, 1'b1, 64'h4, 1'b0, 1'b0, 64'd0, 64'd0);
    #1; chk1("t2_gnt1", bus1.if_gnt, 1'b1);
    step();
    set_in(1'b0, 1'b1, 64'h8, 1'b0, 1'b0, 64'd0, 64'd0);
    #1;
    chk1("t2_gnt2", bus1.if_gnt, 1'b1);
    chk1("t2_l1_rv0", bus1.if_rvalid, 1'b1);
    chk ("t2_l1_rd0", bus1.rdata, 64'hA5A5_5A5A_0000_0000);
    step();
    set_in(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    #1;
    chk1("t2_l1_rv1", bus1.if_rvalid, 1'b1);
    chk ("t2_l1_rd1", bus1.rdata, 64'hA5A5_5A5A_0000_0004);
    chk1("t2_l1_no_dm", bus1.dm_rvalid, 1'b0);
    chk1("t2_l2_rv0", bus2.if_rvalid, 1'b1);
    chk ("t2_l2_rd0", bus2.rdata, 64'hA5A5_5A5A_0000_0000);
    step();
    #1;
    chk ("t2_l1_rd2", bus1.rdata, 64'hA5A5_5A5A_0000_0008);
    step();
    idle(4);

    // simultaneous load and fetch
    set_in(1'b0, 1'b1, 64'h200, 1'b1, 1'b0, 64'h100, 64'd0);
    #1;
    chk1("t3_dm_gnt", bus1.dm_gnt, 1'b1);
    chk1("t3_if_gnt", bus1.if_gnt, 1'b0);
    chk1("t3_stall",  bus1.if_stall, 1'b1);
    step();
    set_in(1'b0, 1'b1, 64'h200, 1'b0, 1'b0, 64'd0, 64'd0);
    #1;
    chk1("t3_if_gnt2", bus1.if_gnt, 1'b1);
    chk1("t3_stall2",  bus1.if_stall, 1'b0);
    step();
    set_in(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    #1;
    chk1("t3_dm_rv", bus1.dm_rvalid, 1'b1);
    chk ("t3_dm_rd", bus1.rdata, 64'hA5A5_5A5A_0000_0100);
    step();
    #1;
    chk1("t3_if_rv", bus1.if_rvalid, 1'b1);
    chk ("t3_if_rd", bus1.rdata, 64'hA5A5_5A5A_0000_0200);
    step();
    idle(4);

    // starvation: data side busy, store/load alternating, fetch waiting
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b1, 64'h300, 1'b1, (i % 2 == 0), 64'h80 + 64'(8 * i), 64'h1000 + 64'(i));
      #1;
      chk1("t4_dm_gnt", bus1.dm_gnt, 1'b1);
      chk1("t4_if_gnt", bus1.if_gnt, 1'b0);
      step();
    end
    set_in(1'b0, 1'b1, 64'h300, 1'b1, 1'b1, 64'hA0, 64'h2000);
    #1;
    chk1("t4_forced_if_gnt", bus1.if_gnt, 1'b1);
    chk1("t4_forced_dm_gnt", bus1.dm_gnt, 1'b0);
    step();
    set_in(1'b0, 1'b1, 64'h304, 1'b1, 1'b1, 64'hA0, 64'h2000);
    #1;
    chk1("t4_resume_dm_gnt", bus1.dm_gnt, 1'b1);
    chk1("t4_resume_if_gnt", bus1.if_gnt, 1'b0);
    step();
    set_in(1'b0, 1'b1, 64'h304, 1'b0, 1'b0, 64'd0, 64'd0);
    step();
    idle(4);

    // store then load back
    set_in(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 64'h40, 64'hDEAD_BEEF);
    #1;
    chk1("t5_st_we", bus1.mem_we, 1'b1);
    chk ("t5_st_wd", bus1.mem_wdata, 64'h0000_0000_DEAD_BEEF);
    step();
    set_in(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 64'h40, 64'd0);
    #1;
    chk1("t5_ld_we",  bus1.mem_we, 1'b0);
    chk1("t5_ld_gnt", bus1.dm_gnt, 1'b1);
    step();
    set_in(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    #1;
    chk1("t5_no_rv_store", bus1.dm_rvalid, 1'b0);
    step();
    #1;
    chk1("t5_l1_rv", bus1.dm_rvalid, 1'b1);
    chk ("t5_l1_rd", bus1.rdata, 64'h0000_0000_DEAD_BEEF);
    step();
    #1;
    chk1("t5_l2_rv", bus2.dm_rvalid, 1'b1);
    chk ("t5_l2_rd", bus2.rdata, 64'h0000_0000_DEAD_BEEF);
    step();
    idle(3);

    // reset one cycle after a load grant drops its response
    set_in(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 64'h48, 64'd0);
    #1; chk1("t6_gnt", bus2.dm_gnt, 1'b1);
    step();
    set_in(1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    step();
    set_in(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    #1;
    chk1("t6_l1_no_rv", bus1.dm_rvalid, 1'b0);
    chk ("t6_l1_rd0",   bus1.rdata, 64'd0);
    step();
    #1;
    chk1("t6_l2_no_rv", bus2.dm_rvalid, 1'b0);
    chk ("t6_l2_rd0",   bus2.rdata, 64'd0);
    step();
    set_in(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 64'h50, 64'd0);
    #1; chk1("t6_post_gnt", bus2.dm_gnt, 1'b1);
    step();
    idle(1);
    set_in(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    #1;
    chk1("t6_post_l1_rv", bus1.dm_rvalid, 1'b1);
    chk ("t6_post_l1_rd", bus1.rdata, 64'hA5A5_5A5A_0000_0050);
    step();
    #1;
    chk1("t6_post_l2_rv", bus2.dm_rvalid, 1'b1);
    chk ("t6_post_l2_rd", bus2.rdata, 64'hA5A5_5A5A_0000_0050);
    step();
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
